// File: rtl/pf_osc_pkg.sv
// -----------------------------------------------------------------------------
// pf_osc_pkg
// Shared definitions for the oscillator clock-enable generator:
//   - top_state_e        : top-level sequencing states (STARTUP, RUN)
//   - DEF_*              : default values for the generator parameters
//   - startup_cnt_width(): width needed to count 0 .. n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package pf_osc_pkg;

  typedef enum logic [0:0] {
    STARTUP = 1'b0,
    RUN     = 1'b1
  } top_state_e;

  localparam int unsigned DEF_NUM_CH         = 4;
  localparam int unsigned DEF_DIV_WIDTH      = 16;
  localparam int unsigned DEF_STARTUP_CYCLES = 1024;

  // Smallest width w (w >= 1) such that 2**w >= n, so a counter of that width
  // can reach n-1.
  function automatic int unsigned startup_cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if (64'(n) > (64'd1 << i)) w = i + 1;
    end
    return w;
  endfunction

endpackage : pf_osc_pkg

// File: rtl/pf_osc_clk_en_gen_if.sv
// -----------------------------------------------------------------------------
// pf_osc_clk_en_gen_if
// Channel control / status bundle of the clock-enable generator.
//   CH_EN      : per-channel run enable                  (master -> slave)
//   DIV_VALUE  : packed divide values, ratio = value + 1 (master -> slave)
//   READY      : startup interval elapsed                (slave -> master)
//   CE_STROBE  : one-cycle clock-enable pulse per period (slave -> master)
//   DIV_OUT    : square wave toggling on each strobe     (slave -> master)
// -----------------------------------------------------------------------------
interface pf_osc_clk_en_gen_if
  import pf_osc_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH
);

  logic [NUM_CH-1:0]           CH_EN;
  logic [NUM_CH*DIV_WIDTH-1:0] DIV_VALUE;
  logic                        READY;
  logic [NUM_CH-1:0]           CE_STROBE;
  logic [NUM_CH-1:0]           DIV_OUT;

  modport master (
    output CH_EN,
    output DIV_VALUE,
    input  READY,
    input  CE_STROBE,
    input  DIV_OUT
  );

  modport slave (
    input  CH_EN,
    input  DIV_VALUE,
    output READY,
    output CE_STROBE,
    output DIV_OUT
  );

endinterface : pf_osc_clk_en_gen_if

// File: rtl/pf_osc_div_chan.sv
// -----------------------------------------------------------------------------
// pf_osc_div_chan
// One divider channel: counter, captured divide value, strobe and toggle flop.
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   run_i        : top is in RUN (channel held cleared otherwise)
//   en_i         : channel enable
//   div_value_i  : requested divide value (ratio = value + 1)
//   strobe_o     : registered one-cycle pulse, once per period
//   div_out_o    : registered square wave, toggles with each strobe
// -----------------------------------------------------------------------------
module pf_osc_div_chan
  import pf_osc_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 run_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_value_i,
  output logic                 strobe_o,
  output logic                 div_out_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 act_q, act_d;
  logic                 strobe_q, strobe_d;
  logic                 div_out_q, div_out_d;

  logic                 active;
  logic                 first;
  logic [DIV_WIDTH-1:0] div_eff;
  logic                 wrap;

  always_comb begin
    active  = run_i & en_i;
    // On the first enabled cycle the captured value is not loaded yet, so the
    // terminal compare uses the live input; afterwards only the captured one.
    first   = active & ~act_q;
    div_eff = first ? div_value_i : div_q;
    wrap    = active & (cnt_q == div_eff);

    act_d     = active;
    cnt_d     = '0;
    div_d     = div_q;
    strobe_d  = 1'b0;
    div_out_d = div_out_q;

    if (!run_i) begin
      div_d     = '0;
      div_out_d = 1'b0;
    end else if (active) begin
      // A new value is only taken at enable or at a wrap, so a mid-period
      // change never truncates or stretches the current period.
      if (first || wrap) div_d = div_value_i;
      if (wrap) begin
        strobe_d  = 1'b1;
        div_out_d = ~div_out_q;
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
    // Disabled in RUN: counter and strobe clear, DIV_OUT holds its level.
    // A wrap coinciding with the disable is suppressed since active is low.
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      div_q     <= '0;
      act_q     <= 1'b0;
      strobe_q  <= 1'b0;
      div_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      act_q     <= act_d;
      strobe_q  <= strobe_d;
      div_out_q <= div_out_d;
    end
  end

  assign strobe_o  = strobe_q;
  assign div_out_o = div_out_q;

endmodule : pf_osc_div_chan

// File: rtl/pf_osc_clk_en_gen.sv
// -----------------------------------------------------------------------------
// pf_osc_clk_en_gen
// Clock-enable generator for a free-running RC oscillator clock. After reset a
// startup interval of STARTUP_CYCLES cycles elapses (READY low), then NUM_CH
// independent dividers produce clock-enable strobes and square waves.
//   CLK    : oscillator clock, all logic on the rising edge
//   RESETN : synchronous active-low reset
//   bus    : slave side of pf_osc_clk_en_gen_if (CH_EN, DIV_VALUE in;
//            READY, CE_STROBE, DIV_OUT out, all driven straight from flops)
// -----------------------------------------------------------------------------
module pf_osc_clk_en_gen
  import pf_osc_pkg::*;
#(
  parameter int unsigned NUM_CH         = DEF_NUM_CH,
  parameter int unsigned DIV_WIDTH      = DEF_DIV_WIDTH,
  parameter int unsigned STARTUP_CYCLES = DEF_STARTUP_CYCLES
) (
  input  logic                CLK,
  input  logic                RESETN,
  pf_osc_clk_en_gen_if.slave  bus
);

  localparam int unsigned      SCW     = startup_cnt_width(STARTUP_CYCLES);
  localparam logic [SCW-1:0]   SC_LAST = SCW'(STARTUP_CYCLES - 1);

  top_state_e     state_q, state_d;
  logic [SCW-1:0] st_cnt_q, st_cnt_d;
  logic           ready_q, ready_d;
  logic           run;

  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] div_out;

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!RESETN) begin
      state_q  <= STARTUP;
      st_cnt_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_cnt_q <= st_cnt_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state logic: count through the startup interval, then stay in RUN
  // until reset.
  always_comb begin
    // NOTE: defaults first, so no path through the block leaves a signal
    // unassigned and infers a latch.
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    case (state_q)
      STARTUP: begin
        if (st_cnt_q == SC_LAST) state_d  = RUN;
        else                     st_cnt_d = st_cnt_q + SCW'(1);
      end
      RUN:     state_d = RUN;
      default: state_d = STARTUP;
    endcase
  end

  // Output logic: READY is registered from the next state so it rises in the
  // same cycle RUN is entered; channels run while the current state is RUN.
  always_comb begin
    ready_d = (state_d == RUN);
    run     = (state_q == RUN);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pf_osc_div_chan #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_chan (
      .clk_i       (CLK),
      .rst_ni      (RESETN),
      .run_i       (run),
      .en_i        (bus.CH_EN[g]),
      .div_value_i (bus.DIV_VALUE[g*DIV_WIDTH +: DIV_WIDTH]),
      .strobe_o    (strobe[g]),
      .div_out_o   (div_out[g])
    );
  end

  assign bus.READY     = ready_q;
  assign bus.CE_STROBE = strobe;
  assign bus.DIV_OUT   = div_out;

endmodule : pf_osc_clk_en_gen
